// File: rtl/pwm_capture.sv
// pwm_capture: measures high time, period and 10-bit duty of an external
// PWM waveform. The input is synchronised and edge-detected, a small FSM
// times rise-to-fall and rise-to-rise, and a 10-step restoring divider
// turns (H, P) into floor(H*1024/P) on the same scale as the PWM duty word.
module pwm_capture #(
    parameter int CNT_WIDTH = 16,
    parameter int TIMEOUT   = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 pwm_in,
    output logic [CNT_WIDTH-1:0] high_cnt,
    output logic [CNT_WIDTH-1:0] period_cnt,
    output logic [9:0]           duty,
    output logic                 valid,
    output logic                 timeout,
    output logic                 busy
);

    typedef enum logic [1:0] {WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;

    localparam logic [CNT_WIDTH-1:0] TO_V = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

    // input conditioning
    logic       s1_q, s2_q, prev_q;
    logic       rise_q, fall_q;
    logic [1:0] arm_q;

    // measurement and divider state
    state_t               state_q;
    logic [CNT_WIDTH-1:0] cnt_q, hlat_q;
    logic [CNT_WIDTH-1:0] div_h_q, div_p_q, rem_q;
    logic [8:0]           quo_q;
    logic [3:0]           dcnt_q;
    logic                 busy_q, valid_q, to_q;
    logic [CNT_WIDTH-1:0] high_q, period_q;
    logic [9:0]           duty_q;

    // divider step and timeout detect
    logic [CNT_WIDTH:0]   shl_d;
    logic                 ge_d;
    logic [CNT_WIDTH-1:0] rem_d;
    logic [9:0]           quo_d;
    logic                 to_hit_d;

    // 2-flop synchroniser, edge register and registered strobes; strobes are
    // held off for 3 cycles after reset so a high pin does not look like a rise
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            arm_q  <= 2'd0;
        end else begin
            s1_q   <= pwm_in;
            s2_q   <= s1_q;
            prev_q <= s2_q;
            if (arm_q != 2'd3) arm_q <= arm_q + 2'd1;
            rise_q <= (arm_q == 2'd3) &&  s2_q && !prev_q;
            fall_q <= (arm_q == 2'd3) && !s2_q &&  prev_q;
        end
    end

    // one restoring step: remainder stays below P, so only one extra bit is needed
    always_comb begin
        shl_d    = {rem_q, 1'b0};
        ge_d     = shl_d >= {1'b0, div_p_q};
        rem_d    = ge_d ? CNT_WIDTH'(shl_d - {1'b0, div_p_q}) : shl_d[CNT_WIDTH-1:0];
        quo_d    = {quo_q, ge_d};
        to_hit_d = (state_q != WAIT_RISE) && (cnt_q == TO_V);
    end

    // measurement FSM, divider and registered outputs
    // priority: rst > enable low > timeout > divider/edges
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= WAIT_RISE;
            cnt_q    <= '0;
            hlat_q   <= '0;
            div_h_q  <= '0;
            div_p_q  <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dcnt_q   <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            to_q     <= 1'b0;
            high_q   <= '0;
            period_q <= '0;
            duty_q   <= '0;
        end else if (!enable) begin
            state_q <= WAIT_RISE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (to_hit_d) begin
                // stuck input: report it and drop whatever was in flight
                to_q     <= 1'b1;
                high_q   <= '0;
                period_q <= '0;
                duty_q   <= (state_q == MEAS_HIGH) ? 10'd1023 : 10'd0;
                valid_q  <= 1'b1;
                busy_q   <= 1'b0;
                state_q  <= WAIT_RISE;
            end else begin
                if (busy_q) begin
                    rem_q  <= rem_d;
                    quo_q  <= quo_d[8:0];
                    dcnt_q <= dcnt_q + 4'd1;
                    if (dcnt_q == 4'd9) begin
                        busy_q   <= 1'b0;
                        high_q   <= div_h_q;
                        period_q <= div_p_q;
                        duty_q   <= quo_d;
                        valid_q  <= 1'b1;
                        to_q     <= 1'b0;
                    end
                end
                case (state_q)
                    WAIT_RISE: begin
                        if (rise_q) begin
                            cnt_q   <= ONE;
                            state_q <= MEAS_HIGH;
                        end
                    end
                    MEAS_HIGH: begin
                        cnt_q <= cnt_q + ONE;
                        if (fall_q) begin
                            hlat_q  <= cnt_q;
                            state_q <= MEAS_LOW;
                        end
                    end
                    MEAS_LOW: begin
                        if (rise_q) begin
                            // closing rise also opens the next period
                            cnt_q   <= ONE;
                            state_q <= MEAS_HIGH;
                            // H < P, so the quotient's upper bits are zero and
                            // the remainder can start at H directly
                            if (!busy_q) begin
                                busy_q  <= 1'b1;
                                rem_q   <= hlat_q;
                                quo_q   <= '0;
                                dcnt_q  <= '0;
                                div_h_q <= hlat_q;
                                div_p_q <= cnt_q;
                            end
                        end else begin
                            cnt_q <= cnt_q + ONE;
                        end
                    end
                    default: state_q <= WAIT_RISE;
                endcase
            end
        end
    end

    assign high_cnt   = high_q;
    assign period_cnt = period_q;
    assign duty       = duty_q;
    assign valid      = valid_q;
    assign timeout    = to_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: instance a uses the default timeout,
// instance b uses TIMEOUT=100. Valid results are recorded per instance.
module tb_pwm_capture;

    logic clk = 1'b0;
    logic rst, enable, pwm_in;

    logic [15:0] a_high, a_per, b_high, b_per;
    logic [9:0]  a_duty, b_duty;
    logic        a_valid, a_to, a_busy, b_valid, b_to, b_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rc = 0;

    pwm_capture u_a (
        .clk(clk), .rst(rst), .enable(enable), .pwm_in(pwm_in),
        .high_cnt(a_high), .period_cnt(a_per), .duty(a_duty),
        .valid(a_valid), .timeout(a_to), .busy(a_busy)
    );

    pwm_capture #(.CNT_WIDTH(16), .TIMEOUT(100)) u_b (
        .clk(clk), .rst(rst), .enable(enable), .pwm_in(pwm_in),
        .high_cnt(b_high), .period_cnt(b_per), .duty(b_duty),
        .valid(b_valid), .timeout(b_to), .busy(b_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // valid-pulse recorders
    int an = 0, a_vc = 0, a_pv = 0, a_h = 0, a_p = 0, a_d = 0, a_t = 0;
    int bn = 0, b_vc = 0, b_h = 0, b_p = 0, b_d = 0, b_t = 0;

    always @(negedge clk) begin
        if (a_valid) begin
            an   <= an + 1;
            a_pv <= a_vc;
            a_vc <= cyc;
            a_h  <= int'(a_high);
            a_p  <= int'(a_per);
            a_d  <= int'(a_duty);
            a_t  <= int'(a_to);
        end
    end

    always @(negedge clk) begin
        if (b_valid) begin
            bn   <= bn + 1;
            b_vc <= cyc;
            b_h  <= int'(b_high);
            b_p  <= int'(b_per);
            b_d  <= int'(b_duty);
            b_t  <= int'(b_to);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int h, input int l);
        pwm_in  = 1'b1;
        last_rc = cyc;
        tick(h);
        pwm_in  = 1'b0;
        tick(l);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int n0, rc;

        // reset with the pin held high: no false rise afterwards
        rst = 1'b1; enable = 1'b1; pwm_in = 1'b1;
        tick(4);
        rst = 1'b0;
        tick(20);
        chk("rst_high",  a_high, 0);
        chk("rst_per",   a_per, 0);
        chk("rst_duty",  a_duty, 0);
        chk("rst_valid", a_valid, 0);
        chk("rst_to",    a_to, 0);
        chk("rst_busy",  a_busy, 0);
        chk("rst_na",    an, 0);
        chk("rst_nb",    bn, 0);
        pwm_in = 1'b0;
        tick(10);

        // steady 25%: valid 14 cycles after the pin rises (3 to strobe + 11)
        for (int i = 0; i < 5; i++) begin
            pulse(256, 768);
            if (i > 0) begin
                chk("q25_lat",  a_vc - last_rc, 14);
                chk("q25_duty", a_d, 256);
                chk("q25_n",    an, i);
            end
        end
        chk("q25_high", a_h, 256);
        chk("q25_per",  a_p, 1024);

        // 300/700 -> 307 (first rise closes the last 256/1024 period)
        for (int i = 0; i < 3; i++) pulse(300, 700);
        chk("r307_lat",  a_vc - last_rc, 14);
        chk("r307_duty", a_d, 307);
        chk("r307_high", a_h, 300);
        chk("r307_per",  a_p, 1000);
        chk("r307_n",    an, 7);
        pulse(500, 500);
        chk("r307b_n",   an, 8);

        // enable drop mid-division: the 500/1000 result never appears
        n0 = an;
        pwm_in = 1'b1;
        rc = cyc;
        tick(5);
        chk("en_busy1", a_busy, 1);
        enable = 1'b0;
        tick(1);
        chk("en_busy0", a_busy, 0);
        enable = 1'b1;
        tick(494);
        pwm_in = 1'b0;
        tick(500);
        chk("en_noval", an, n0);
        chk("en_hduty", a_duty, 307);
        chk("en_hhigh", a_high, 300);
        chk("en_hper",  a_per, 1000);
        pulse(500, 500);
        chk("en_open",  an, n0);
        pulse(500, 500);
        chk("en_n",     an, n0 + 1);
        chk("en_lat",   a_vc - last_rc, 14);
        chk("en_duty",  a_d, 512);
        chk("en_high",  a_h, 500);
        chk("rc_unused_guard", rc + 5, last_rc - 2000 + 5);

        // H=1 L=2: the divider is busy for 10 cycles, so only every 4th period lands
        n0 = an;
        for (int i = 0; i < 12; i++) pulse(1, 2);
        tick(10);
        chk("h1_n",    an - n0, 3);
        chk("h1_gap",  a_vc - a_pv, 12);
        chk("h1_duty", a_d, 341);
        chk("h1_high", a_h, 1);
        chk("h1_per",  a_p, 3);

        // timeouts on the TIMEOUT=100 instance
        rst = 1'b1; pwm_in = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(5);
        chk("to_rst", b_to, 0);
        n0 = bn;
        pulse(150, 0);
        chk("toh_lat",  b_vc - last_rc, 104);
        chk("toh_duty", b_d, 1023);
        chk("toh_flag", b_t, 1);
        chk("toh_high", b_h, 0);
        chk("toh_per",  b_p, 0);
        chk("toh_n",    bn - n0, 1);
        chk("toh_busy", b_busy, 0);
        tick(200);
        chk("tol_noval", bn - n0, 1);
        chk("tol_level", b_to, 1);
        pulse(10, 150);
        chk("tolow_lat",  b_vc - last_rc, 104);
        chk("tolow_duty", b_d, 0);
        chk("tolow_flag", b_t, 1);
        chk("tolow_n",    bn - n0, 2);
        pulse(10, 30);
        pulse(10, 30);
        chk("res_lat",  b_vc - last_rc, 14);
        chk("res_flag", b_t, 0);
        chk("res_duty", b_d, 256);
        chk("res_high", b_h, 10);
        chk("res_per",  b_p, 40);
        chk("res_n",    bn - n0, 3);

        // rst during MEAS_LOW on instance a
        pulse(30, 50);
        pulse(30, 50);
        chk("pre_duty", a_d, 384);
        chk("pre_per",  a_p, 80);
        pwm_in = 1'b1;
        tick(30);
        pwm_in = 1'b0;
        tick(10);
        rst = 1'b1;
        tick(1);
        chk("mr_high",  a_high, 0);
        chk("mr_per",   a_per, 0);
        chk("mr_duty",  a_duty, 0);
        chk("mr_valid", a_valid, 0);
        chk("mr_to",    a_to, 0);
        chk("mr_busy",  a_busy, 0);
        rst = 1'b0;
        tick(40);
        n0 = an;
        pulse(30, 50);
        chk("mr_first", an, n0);
        pulse(30, 50);
        chk("mr_n",    an - n0, 1);
        chk("mr_lat",  a_vc - last_rc, 14);
        chk("mr_vdut", a_d, 384);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
